aes_scan_harness: RTL
=====================

AES_SCAN_HARNESS -- requirements
Module: aes_scan_harness

Interface
REQ-001 Parameter DATA_W, default 128: width of the plaintext/state register and the result buffer.
REQ-002 Parameter KEY_W, default 128: width of the key register.
REQ-003 Parameter SCAN_W, default 1: scan lane width; SHALL divide both DATA_W and KEY_W.
REQ-004 Parameter CORE_LAT, default 21: cycles from launch to valid core result; range 1..255.
REQ-005 Port CLK, input, 1: sole clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port scan_in_enable, input, 1: shift one SCAN_W lane into the selected input register.
REQ-008 Port scan_in_sel, input, 1: 0 selects the data register, 1 selects the key register.
REQ-009 Port scan_in_data, input, SCAN_W: scan-in lane.
REQ-010 Port start, input, 1: request one encryption with the current data and key.
REQ-011 Port busy, output, 1: encryption in flight.
REQ-012 Port done, output, 1: one-cycle pulse when the result is captured.
REQ-013 Port scan_out_enable, input, 1: shift one lane out of the result buffer.
REQ-014 Port scan_out_data, output, SCAN_W: scan-out lane, registered.
REQ-015 Port scan_out_valid, output, 1: scan_out_data holds a valid result lane, registered.
REQ-016 Port core_state, output, DATA_W: direct drive from the data register.
REQ-017 Port core_key, output, KEY_W: direct drive from the key register.
REQ-018 Port core_output, input, DATA_W: result from the external pipelined AES core.

Function
REQ-019 Scan-in SHALL operate only when the FSM is not BUSY.
- Data register update: data <= {data[DATA_W-SCAN_W-1:0], scan_in_data}.
- Key register update: same form.
- Only the register chosen by scan_in_sel shifts.
REQ-020 While BUSY, scan_in_enable SHALL be ignored, so core_state and core_key stay constant for the whole computation.
REQ-021 The FSM SHALL have three states: IDLE, BUSY and READY.
REQ-022 In IDLE or READY, start=1 SHALL:
- enter BUSY;
- load the latency counter with CORE_LAT-1;
- invalidate the result buffer (scan_out_valid=0 on the next cycle).
REQ-023 In BUSY, the counter SHALL decrement each cycle, and start SHALL be ignored.
REQ-024 In BUSY with counter=0, the block SHALL on that edge:
- capture core_output into the result buffer;
- set the shift count to DATA_W/SCAN_W;
- pulse done=1 for exactly one cycle;
- enter READY.
REQ-025 Latency: done SHALL assert CORE_LAT cycles after the edge that samples start; busy SHALL be high for exactly CORE_LAT cycles.
REQ-026 In READY, scan_out_enable=1 with a nonzero shift count SHALL, on the next cycle:
- set scan_out_data to buffer[SCAN_W-1:0] (LSB lane first);
- set scan_out_valid=1;
- shift the buffer right by SCAN_W with zero fill;
- decrement the shift count.
REQ-027 Otherwise scan_out_data SHALL be 0 and scan_out_valid SHALL be 0.
REQ-028 When the shift count reaches 0 (buffer exhausted), further scan_out_enable SHALL yield data 0 and valid 0.
- The FSM stays in READY until the next start.
REQ-029 scan_out_enable outside READY SHALL have no effect.
REQ-030 Simultaneous events:
- start and scan_out_enable in READY: start wins, and no lane is emitted.
- scan_in_enable and start in IDLE or READY: the shift occurs and the shifted value is launched.
REQ-031 Arithmetic: counters SHALL be sized for CORE_LAT and DATA_W/SCAN_W without wrap; no other arithmetic.

Reset
REQ-032 On rst=1, asynchronously, the block SHALL clear all state:
- FSM=IDLE, counter=0, shift count=0;
- data, key and result buffer all 0;
- busy=0, done=0, scan_out_data=0, scan_out_valid=0.
REQ-033 Reset during BUSY SHALL abort the computation with no done pulse, and the in-flight core result SHALL never be captured.
REQ-034 After rst deasserts, the first start SHALL behave as from IDLE.

Verification
REQ-035 Bench configuration: DATA_W=KEY_W=128, SCAN_W=1, CORE_LAT=3; the bench models the core as core_output = core_state XOR core_key, delayed 3 cycles.
REQ-036 Scan-in: 128 data lanes of 0x000102...0F, MSB first, then 128 key lanes of all-ones -> core_state=0x000102030405060708090A0B0C0D0E0F and core_key=all-ones.
REQ-037 Latency: start for 1 cycle -> busy high for 3 cycles, done pulses on cycle 3, buffer = 0xFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0.
REQ-038 Scan-out: 130 cycles of scan_out_enable -> 128 valid lanes, LSB first (first lane 0, then 0,0,0,1,1,1,1), then 2 cycles of valid=0 and data=0.
REQ-039 Blocking: scan_in_enable and a second start during BUSY -> core_state unchanged, exactly one done pulse, busy length still 3.
REQ-040 Reset mid-operation: rst asserted on the second BUSY cycle -> outputs zero immediately, no done pulse; a later start completes with buffer = 0 XOR 0 = 0.

Source files
------------

// File: rtl/aes_scan_harness.sv
// Scan-chain wrapper around an external pipelined AES core.
// Serial load of data/key, fixed-latency launch, serial unload of the result.
module aes_scan_harness #(
  parameter int DATA_W   = 128,
  parameter int KEY_W    = 128,
  parameter int SCAN_W   = 1,
  parameter int CORE_LAT = 21
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              scan_in_enable,
  input  logic              scan_in_sel,
  input  logic [SCAN_W-1:0] scan_in_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              scan_out_enable,
  output logic [SCAN_W-1:0] scan_out_data,
  output logic              scan_out_valid,
  output logic [DATA_W-1:0] core_state,
  output logic [KEY_W-1:0]  core_key,
  input  logic [DATA_W-1:0] core_output
);

  localparam int LANES = DATA_W / SCAN_W;
  localparam int CW    = $clog2(CORE_LAT + 1);
  localparam int SHW   = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] data_q;
  logic [KEY_W-1:0]  key_q;
  logic [DATA_W-1:0] buf_q;
  logic [CW-1:0]     cnt_q;
  logic [SHW-1:0]    shcnt_q;
  logic [SCAN_W-1:0] sod_q;
  logic              sov_q;
  logic              done_q;

  logic launch;
  logic capture;
  logic emit;
  logic shift_in;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // start beats scan-out in READY; scan-in is frozen only while BUSY
  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    capture  = 1'b0;
    emit     = 1'b0;
    shift_in = scan_in_enable && (state_q != BUSY);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          launch  = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = READY;
          capture = 1'b1;
        end
      end
      READY: begin
        if (start) begin
          state_d = BUSY;
          launch  = 1'b1;
        end else if (scan_out_enable && shcnt_q != '0) begin
          emit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      key_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      shcnt_q <= '0;
      sod_q   <= '0;
      sov_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= capture;
      if (shift_in && !scan_in_sel)
        data_q <= {data_q[DATA_W-SCAN_W-1:0], scan_in_data};
      if (shift_in && scan_in_sel)
        key_q <= {key_q[KEY_W-SCAN_W-1:0], scan_in_data};
      if (launch)
        cnt_q <= CW'(CORE_LAT - 1);
      else if (state_q == BUSY && cnt_q != '0)
        cnt_q <= cnt_q - CW'(1);
      if (launch)
        shcnt_q <= '0;
      else if (capture)
        shcnt_q <= SHW'(LANES);
      else if (emit)
        shcnt_q <= shcnt_q - SHW'(1);
      if (capture)
        buf_q <= core_output;
      else if (emit)
        buf_q <= buf_q >> SCAN_W;
      sod_q <= emit ? buf_q[SCAN_W-1:0] : '0;
      sov_q <= emit;
    end
  end

  assign busy           = (state_q == BUSY);
  assign done           = done_q;
  assign scan_out_data  = sod_q;
  assign scan_out_valid = sov_q;
  assign core_state     = data_q;
  assign core_key       = key_q;

endmodule
